// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the MEM-stage access controller
package mem_pkg;

  typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_STORE, OP_RSVD} op_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;

  // Wide enough for TIMEOUT up to 255
  localparam int TO_CW = 8;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte enables, store lane replication, load extract and extend
module mem_lane_align
  import mem_pkg::*;
#(
  parameter  int DW = 32,
  localparam int NB = DW / 8,
  localparam int LB = $clog2(NB)
) (
  input  size_e          size,
  input  logic [LB-1:0]  off,
  input  logic           uns,
  input  logic [DW-1:0]  wdata_in,
  input  logic [DW-1:0]  rdata_in,
  output logic [NB-1:0]  be,
  output logic [DW-1:0]  wdata,
  output logic [DW-1:0]  rdata_ext
);

  logic [DW-1:0] sh;
  logic [DW-1:0] mask;
  logic          sign;

  always_comb begin
    be        = '0;
    wdata     = '0;
    mask      = '1;
    sign      = 1'b0;
    rdata_ext = '0;
    // Lowest selected lane moves to bit 0 before extension
    sh = rdata_in >> {off, 3'b000};
    case (size)
      SZ_B: begin
        be    = NB'(1) << off;
        wdata = {NB{wdata_in[7:0]}};
        mask  = DW'(8'hFF);
        sign  = ~uns & sh[7];
      end
      SZ_H: begin
        be    = NB'(3) << {off[LB-1:1], 1'b0};
        wdata = {(NB/2){wdata_in[15:0]}};
        mask  = DW'(16'hFFFF);
        sign  = ~uns & sh[15];
      end
      SZ_W: begin
        be    = (DW == 64) ? (NB'(8'h0F) << {off[LB-1], 2'b00}) : '1;
        wdata = {(DW/32){wdata_in[31:0]}};
        mask  = DW'(32'hFFFF_FFFF);
        sign  = ~uns & sh[31];
      end
      default: begin
        be    = '1;
        wdata = wdata_in;
        mask  = '1;
        sign  = 1'b0;
      end
    endcase
    rdata_ext = (sh & mask) | ({DW{sign}} & ~mask);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data cache access controller; MEM_MISALIGN_TRAP_EN traps misaligned accesses
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter  int AW      = 32,
  parameter  int DW      = 32,
  parameter  int TIMEOUT = 15,
  localparam int NB      = DW / 8,
  localparam int LB      = $clog2(NB)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_i,
  input  logic [1:0]    op_i,
  input  logic [1:0]    size_i,
  input  logic          unsigned_i,
  input  logic [AW-1:0] address_i,
  input  logic [DW-1:0] data_i,
  output logic          stall_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          err_o,
  output logic          req_o,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic [NB-1:0] be_o,
  output logic [DW-1:0] wdata_o,
  input  logic          ack_i,
  input  logic [DW-1:0] rdata_i
);

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e             st, st_nx;
  logic [TO_CW-1:0]   cnt;
  logic [AW-1:0]      a_q;
  size_e              sz_q;
  logic               uns_q, we_q, err_q;
  logic [DW-1:0]      wd_q, rd_q;

  op_e                op_in;
  size_e              sz_in;
  logic [LB-1:0]      lo_m;
  logic               accept, trap, timeout;
  logic [NB-1:0]      be;
  logic [DW-1:0]      wd_rep, ext;

  always_comb begin
    op_in = op_e'(op_i);
    sz_in = size_e'(size_i);
    if (DW == 32 && sz_in == SZ_D) sz_in = SZ_W;
    case (sz_in)
      SZ_B:    lo_m = '0;
      SZ_H:    lo_m = LB'(1);
      SZ_W:    lo_m = LB'(3);
      default: lo_m = LB'(7);
    endcase
  end

  assign accept  = valid_i && (op_in == OP_LOAD || op_in == OP_STORE);
  assign trap    = TRAP_EN && (|(address_i[LB-1:0] & lo_m));
  assign timeout = (cnt == TO_CW'(TIMEOUT - 1));

  always_comb begin
    st_nx   = st;
    stall_o = 1'b0;
    valid_o = 1'b0;
    data_o  = '0;
    err_o   = 1'b0;
    case (st)
      ST_IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          st_nx   = trap ? ST_RESP : ST_REQ;
        end else begin
          valid_o = valid_i;
          data_o  = data_i;
        end
      end
      ST_REQ: begin
        stall_o = 1'b1;
        if (ack_i || timeout) st_nx = ST_RESP;
      end
      ST_RESP: begin
        valid_o = 1'b1;
        err_o   = err_q;
        data_o  = (err_q || we_q) ? '0 : ext;
        st_nx   = ST_IDLE;
      end
      default: st_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= ST_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      sz_q  <= SZ_B;
      uns_q <= 1'b0;
      we_q  <= 1'b0;
      err_q <= 1'b0;
      wd_q  <= '0;
      rd_q  <= '0;
    end else begin
      st <= st_nx;
      case (st)
        ST_IDLE: begin
          cnt <= '0;
          if (accept) begin
            // Misaligned low bits are dropped; under trap the access never issues
            a_q   <= address_i & ~AW'(lo_m);
            sz_q  <= sz_in;
            uns_q <= unsigned_i;
            we_q  <= (op_in == OP_STORE);
            wd_q  <= data_i;
            rd_q  <= '0;
            err_q <= trap;
          end
        end
        ST_REQ: begin
          cnt <= cnt + 1'b1;
          if (ack_i) begin
            rd_q  <= rdata_i;
            err_q <= 1'b0;
          end else if (timeout) begin
            err_q <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  mem_lane_align #(.DW(DW)) u_align (
    .size      (sz_q),
    .off       (a_q[LB-1:0]),
    .uns       (uns_q),
    .wdata_in  (wd_q),
    .rdata_in  (rd_q),
    .be        (be),
    .wdata     (wd_rep),
    .rdata_ext (ext)
  );

  assign req_o   = (st == ST_REQ);
  assign we_o    = req_o & we_q;
  assign addr_o  = req_o ? {a_q[AW-1:LB], {LB{1'b0}}} : '0;
  assign be_o    = req_o ? be : '0;
  assign wdata_o = req_o ? wd_rep : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl (DW=32, TIMEOUT=15)
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_i;
  logic [1:0]    op_i, size_i;
  logic          unsigned_i;
  logic [AW-1:0] address_i;
  logic [DW-1:0] data_i;
  logic          stall_o, valid_o, err_o, req_o, we_o;
  logic [DW-1:0] data_o, wdata_o, rdata_i;
  logic [AW-1:0] addr_o;
  logic [3:0]    be_o;
  logic          ack_i;

  int            n_chk = 0;
  int            n_pass = 0;
  logic [32:0]   sb_q[$];
  logic [32:0]   sb_e;

  always #5 clk = ~clk;

  mem_access_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .op_i(op_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .address_i(address_i), .data_i(data_i),
    .stall_o(stall_o), .valid_o(valid_o), .data_o(data_o), .err_o(err_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .be_o(be_o), .wdata_o(wdata_o),
    .ack_i(ack_i), .rdata_i(rdata_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!reset && valid_o) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", valid_o, 1'b0);
      end else begin
        sb_e = sb_q.pop_front();
        check("data_o", data_o, sb_e[31:0]);
        check("err_o", err_o, sb_e[32]);
      end
    end
  end

  task automatic idle_inputs();
    valid_i = 1'b0; op_i = 2'b00; size_i = 2'b00; unsigned_i = 1'b0;
    address_i = '0; data_i = '0;
  endtask

  task automatic pass_op(input logic [1:0] op, input logic [31:0] d);
    @(posedge clk); #1;
    sb_q.push_back({1'b0, d});
    valid_i = 1'b1; op_i = op; data_i = d;
    #1;
    check("pt_stall", stall_o, 1'b0);
    check("pt_req", req_o, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    check("pt_drain", sb_q.size(), 0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int ack_dly,
                        input logic [31:0] rd, input logic [3:0] ebe, input logic [31:0] eaddr,
                        input logic [31:0] ewd, input int ereqs, input logic [31:0] edata,
                        input logic eerr);
    int reqs, stalls;
    reqs = 0; stalls = 0;
    @(posedge clk); #1;
    sb_q.push_back({eerr, edata});
    valid_i = 1'b1; op_i = op; size_i = sz; unsigned_i = uns; address_i = addr; data_i = wd;
    #1;
    check("acc_stall", stall_o, 1'b1);
    if (stall_o) stalls++;
    @(posedge clk); #1;
    idle_inputs();
    for (int c = 0; c < 40 && req_o; c++) begin
      reqs++;
      if (stall_o) stalls++;
      if (c == 0) begin
        check("be_o", be_o, ebe);
        check("addr_o", addr_o, eaddr);
        check("we_o", we_o, (op == 2'b10));
        check("wdata_o", wdata_o, ewd);
      end
      if (c == ack_dly) begin
        ack_i = 1'b1; rdata_i = rd;
      end
      @(posedge clk); #1;
      ack_i = 1'b0; rdata_i = '0;
    end
    check("req_cycles", reqs, ereqs);
    check("stall_cycles", stalls, ereqs + 1);
    check("resp_stall", stall_o, 1'b0);
    @(posedge clk); #1;
    check("sb_drain", sb_q.size(), 0);
  endtask

  initial begin
    logic [31:0] rd, exp_d;
    logic [7:0]  b;
    logic [3:0]  ebe;
    int          off;
    logic        uns;

    reset = 1'b1; ack_i = 1'b0; rdata_i = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", req_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_be", be_o, 4'h0);
    check("rst_we", we_o, 1'b0);
    check("rst_addr", addr_o, 32'h0);
    reset = 1'b0;

    pass_op(2'b00, 32'hCAFE_F00D);
    pass_op(2'b11, 32'h1357_9BDF);

    // word load, ack on second REQ cycle
    run_op(2'b01, 2'b10, 1'b0, 32'h100, 32'h0, 1, 32'hDEAD_BEEF, 4'hF, 32'h100, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);
    // signed / unsigned byte loads at lane 3
    run_op(2'b01, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h8000_0000, 4'h8, 32'h100, 32'h0, 1, 32'hFFFF_FF80, 1'b0);
    run_op(2'b01, 2'b00, 1'b1, 32'h103, 32'h0, 0, 32'h8000_0000, 4'h8, 32'h100, 32'h0, 1, 32'h0000_0080, 1'b0);
    // half store, same-cycle ack
    run_op(2'b10, 2'b01, 1'b0, 32'h102, 32'h1234, 0, 32'h0, 4'hC, 32'h100, 32'h1234_1234, 1, 32'h0, 1'b0);
    // signed half load upper lane, unsigned byte lane 1
    run_op(2'b01, 2'b01, 1'b0, 32'h102, 32'h0, 2, 32'h8001_0000, 4'hC, 32'h100, 32'h0, 3, 32'hFFFF_8001, 1'b0);
    run_op(2'b01, 2'b00, 1'b1, 32'h201, 32'h0, 0, 32'h0000_AB00, 4'h2, 32'h200, 32'h0, 1, 32'h0000_00AB, 1'b0);
    // byte store replication
    run_op(2'b10, 2'b00, 1'b0, 32'h202, 32'h5A, 0, 32'h0, 4'h4, 32'h200, 32'h5A5A_5A5A, 1, 32'h0, 1'b0);
    // dword request on DW=32 behaves as a word
    run_op(2'b01, 2'b11, 1'b0, 32'h208, 32'h0, 0, 32'h0BAD_F00D, 4'hF, 32'h208, 32'h0, 1, 32'h0BAD_F00D, 1'b0);
    // cache never acks
    run_op(2'b01, 2'b10, 1'b0, 32'h300, 32'h0, -1, 32'h0, 4'hF, 32'h300, 32'h0, TIMEOUT, 32'h0, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
    run_op(2'b01, 2'b10, 1'b0, 32'h102, 32'h0, 0, 32'h1122_3344, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1);
`else
    run_op(2'b01, 2'b10, 1'b0, 32'h102, 32'h0, 0, 32'h1122_3344, 4'hF, 32'h100, 32'h0, 1, 32'h1122_3344, 1'b0);
`endif

    for (int i = 0; i < 6; i++) begin
      off = $urandom_range(0, 3);
      rd  = $urandom;
      uns = 1'($urandom_range(0, 1));
      b   = rd[8*off +: 8];
      exp_d = uns ? {24'h0, b} : {{24{b[7]}}, b};
      ebe = 4'b0001 << off;
      run_op(2'b01, 2'b00, uns, 32'h400 + 32'(off), 32'h0, i % 3, rd, ebe, 32'h400, 32'h0, (i % 3) + 1, exp_d, 1'b0);
    end

    // reset during REQ cycle 2, then a late ack
    @(posedge clk); #1;
    valid_i = 1'b1; op_i = 2'b01; size_i = 2'b10; address_i = 32'h500;
    @(posedge clk); #1;
    idle_inputs();
    check("rq_req1", req_o, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rr_req", req_o, 1'b0);
    check("rr_stall", stall_o, 1'b0);
    reset = 1'b0; ack_i = 1'b1; rdata_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    ack_i = 1'b0; rdata_i = '0;
    check("rr_valid", valid_o, 1'b0);
    check("rr_req2", req_o, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rr_drain", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
